// File: rtl/operate_uart_tx.sv
// operate_uart_tx: 8N1 UART transmitter for operation codes.
// One frame is sent each time data_in changes. A one-deep pending slot holds
// the newest code while a frame is in flight.
module operate_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter logic [7:0]  RESET_CODE   = 8'h00
) (
  input  logic       uart_clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic       drop
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  last_seen, last_seen_nxt;
  logic [7:0]  pending, pending_nxt;
  logic        pending_valid, pending_valid_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [15:0] baud_cnt, baud_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic        tx_nxt, busy_nxt, frame_done_nxt, drop_nxt;
  logic        change, consume, baud_end;

  // Change detect and pending slot; an IDLE load frees the slot on the same edge.
  always_comb begin
    change            = (data_in != last_seen);
    consume           = (state == IDLE) && pending_valid;
    last_seen_nxt     = last_seen;
    pending_nxt       = pending;
    pending_valid_nxt = pending_valid;
    drop_nxt          = 1'b0;
    if (change) begin
      last_seen_nxt     = data_in;
      pending_nxt       = data_in;
      pending_valid_nxt = 1'b1;
      drop_nxt          = pending_valid && !consume;
    end else if (consume) begin
      pending_valid_nxt = 1'b0;
    end
  end

  // Frame sequencer: next state, baud/bit counters, shift register and outputs.
  always_comb begin
    baud_end       = (baud_cnt == BAUD_LAST);
    state_nxt      = state;
    shift_nxt      = shift;
    bit_cnt_nxt    = bit_cnt;
    baud_nxt       = baud_end ? '0 : baud_cnt + 16'd1;
    tx_nxt         = tx;
    busy_nxt       = busy;
    frame_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        baud_nxt = '0;
        if (pending_valid) begin
          shift_nxt = pending;
          tx_nxt    = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (baud_end) begin
          tx_nxt      = shift[0];
          bit_cnt_nxt = '0;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            tx_nxt      = shift[1];
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          frame_done_nxt = 1'b1;
          busy_nxt       = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: begin
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
        baud_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and discards pending.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_seen     <= RESET_CODE;
      pending       <= '0;
      pending_valid <= 1'b0;
      shift         <= '0;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      tx            <= 1'b1;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      drop          <= 1'b0;
    end else begin
      state         <= state_nxt;
      last_seen     <= last_seen_nxt;
      pending       <= pending_nxt;
      pending_valid <= pending_valid_nxt;
      shift         <= shift_nxt;
      baud_cnt      <= baud_nxt;
      bit_cnt       <= bit_cnt_nxt;
      tx            <= tx_nxt;
      busy          <= busy_nxt;
      frame_done    <= frame_done_nxt;
      drop          <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_operate_uart_tx.sv
// Directed testbench for operate_uart_tx (CLKS_PER_BIT=4 and =1 instances).
module tb_operate_uart_tx;

  logic       uart_clk;
  logic       rst_n;
  logic [7:0] d4, d1;
  logic       tx4, busy4, fd4, drop4;
  logic       tx1, busy1, fd1, drop1;

  int total = 0;
  int bad   = 0;
  int drop_cnt4 = 0, fd_cnt4 = 0, drop_cnt1 = 0, fd_cnt1 = 0;

  operate_uart_tx #(.CLKS_PER_BIT(4), .RESET_CODE(8'h00)) dut4 (
    .uart_clk(uart_clk), .rst_n(rst_n), .data_in(d4),
    .tx(tx4), .busy(busy4), .frame_done(fd4), .drop(drop4)
  );

  operate_uart_tx #(.CLKS_PER_BIT(1), .RESET_CODE(8'h00)) dut1 (
    .uart_clk(uart_clk), .rst_n(rst_n), .data_in(d1),
    .tx(tx1), .busy(busy1), .frame_done(fd1), .drop(drop1)
  );

  initial uart_clk = 1'b0;
  always #5 uart_clk = ~uart_clk;

  // Pulse counters, sampled shortly after each rising edge.
  always @(posedge uart_clk) begin
    #2;
    if (drop4 === 1'b1) drop_cnt4++;
    if (fd4   === 1'b1) fd_cnt4++;
    if (drop1 === 1'b1) drop_cnt1++;
    if (fd1   === 1'b1) fd_cnt1++;
  end

  // Expected line level in cycle k of a frame carrying code.
  function automatic logic exp_tx(input logic [7:0] code, input int k, input int cpb);
    int b;
    b = k / cpb;
    if (b == 0) return 1'b0;
    if (b <= 8) return code[b-1];
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    d4 = 8'h00;
    d1 = 8'h00;
    repeat (3) @(negedge uart_clk);
    total++;
    if ({tx4, busy4, fd4, drop4} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_dut4: got tx/busy/fd/drop=%b want 1000", {tx4, busy4, fd4, drop4});
    end
    total++;
    if ({tx1, busy1, fd1, drop1} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_dut1: got tx/busy/fd/drop=%b want 1000", {tx1, busy1, fd1, drop1});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge uart_clk);
      total++;
      if ({tx4, busy4, fd4, drop4, tx1, busy1, fd1, drop1} !== 8'b1000_1000) begin
        bad++;
        $display("FAIL idle_hold cycle %0d: got %b want 10001000", i,
                 {tx4, busy4, fd4, drop4, tx1, busy1, fd1, drop1});
      end
    end
  endtask

  task automatic test_frame_drop();
    int drops0, fds0;
    drops0 = drop_cnt4;
    fds0   = fd_cnt4;
    d4 = 8'h35;
    @(negedge uart_clk);
    total++;
    if ({tx4, busy4} !== 2'b10) begin
      bad++;
      $display("FAIL latency_35: got tx/busy=%b want 10 one edge after change", {tx4, busy4});
    end
    @(negedge uart_clk);
    for (int k = 0; k < 40; k++) begin
      total++;
      if (tx4 !== exp_tx(8'h35, k, 4) || busy4 !== 1'b1) begin
        bad++;
        $display("FAIL frame_35 k=%0d: got tx=%b busy=%b want tx=%b busy=1", k, tx4, busy4,
                 exp_tx(8'h35, k, 4));
      end
      if (k == 10) d4 = 8'h0A;
      if (k == 20) d4 = 8'h0C;
      @(negedge uart_clk);
    end
    total++;
    if ({tx4, busy4, fd4} !== 3'b101) begin
      bad++;
      $display("FAIL done_35: got tx/busy/fd=%b want 101", {tx4, busy4, fd4});
    end
    @(negedge uart_clk);
    for (int k = 0; k < 40; k++) begin
      total++;
      if (tx4 !== exp_tx(8'h0C, k, 4) || busy4 !== 1'b1) begin
        bad++;
        $display("FAIL frame_0C k=%0d: got tx=%b busy=%b want tx=%b busy=1", k, tx4, busy4,
                 exp_tx(8'h0C, k, 4));
      end
      @(negedge uart_clk);
    end
    total++;
    if ({tx4, busy4, fd4} !== 3'b101) begin
      bad++;
      $display("FAIL done_0C: got tx/busy/fd=%b want 101", {tx4, busy4, fd4});
    end
    repeat (3) @(negedge uart_clk);
    total++;
    if ({tx4, busy4, fd4} !== 3'b100) begin
      bad++;
      $display("FAIL idle_after_0C: got tx/busy/fd=%b want 100 (0A must not be sent)", {tx4, busy4, fd4});
    end
    total++;
    if (drop_cnt4 - drops0 !== 1) begin
      bad++;
      $display("FAIL drop_count: got %0d want 1", drop_cnt4 - drops0);
    end
    total++;
    if (fd_cnt4 - fds0 !== 2) begin
      bad++;
      $display("FAIL frame_done_count: got %0d want 2", fd_cnt4 - fds0);
    end
  endtask

  task automatic test_back_to_back();
    int drops0;
    drops0 = drop_cnt4;
    d4 = 8'h35;
    @(negedge uart_clk);
    total++;
    if ({tx4, busy4} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_pre: got tx/busy=%b want 10", {tx4, busy4});
    end
    d4 = 8'h81;
    @(negedge uart_clk);
    for (int k = 0; k < 40; k++) begin
      total++;
      if (tx4 !== exp_tx(8'h35, k, 4) || busy4 !== 1'b1) begin
        bad++;
        $display("FAIL b2b_35 k=%0d: got tx=%b busy=%b want tx=%b busy=1", k, tx4, busy4,
                 exp_tx(8'h35, k, 4));
      end
      @(negedge uart_clk);
    end
    total++;
    if ({tx4, busy4, fd4} !== 3'b101) begin
      bad++;
      $display("FAIL b2b_gap: got tx/busy/fd=%b want 101", {tx4, busy4, fd4});
    end
    @(negedge uart_clk);
    for (int k = 0; k < 40; k++) begin
      total++;
      if (tx4 !== exp_tx(8'h81, k, 4) || busy4 !== 1'b1) begin
        bad++;
        $display("FAIL b2b_81 k=%0d: got tx=%b busy=%b want tx=%b busy=1", k, tx4, busy4,
                 exp_tx(8'h81, k, 4));
      end
      @(negedge uart_clk);
    end
    total++;
    if ({tx4, busy4, fd4} !== 3'b101) begin
      bad++;
      $display("FAIL b2b_done_81: got tx/busy/fd=%b want 101", {tx4, busy4, fd4});
    end
    total++;
    if (drop_cnt4 - drops0 !== 0) begin
      bad++;
      $display("FAIL b2b_drop: got %0d drops want 0", drop_cnt4 - drops0);
    end
    @(negedge uart_clk);
  endtask

  task automatic test_reset_midframe();
    d4 = 8'h3C;
    repeat (2) @(negedge uart_clk);
    // k=0 now; advance into data bit 3 (cycles 16..19)
    repeat (17) @(negedge uart_clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({tx4, busy4} !== 2'b10) begin
      bad++;
      $display("FAIL async_abort: got tx/busy=%b want 10", {tx4, busy4});
    end
    d4 = 8'h00;
    @(negedge uart_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge uart_clk);
      total++;
      if ({tx4, busy4, fd4} !== 3'b100) begin
        bad++;
        $display("FAIL post_reset_quiet cycle %0d: got tx/busy/fd=%b want 100", i, {tx4, busy4, fd4});
      end
    end
    d4 = 8'h3C;
    @(negedge uart_clk);
    @(negedge uart_clk);
    for (int k = 0; k < 40; k++) begin
      total++;
      if (tx4 !== exp_tx(8'h3C, k, 4) || busy4 !== 1'b1) begin
        bad++;
        $display("FAIL post_reset_3C k=%0d: got tx=%b busy=%b want tx=%b busy=1", k, tx4, busy4,
                 exp_tx(8'h3C, k, 4));
      end
      @(negedge uart_clk);
    end
    total++;
    if ({tx4, busy4, fd4} !== 3'b101) begin
      bad++;
      $display("FAIL post_reset_done: got tx/busy/fd=%b want 101", {tx4, busy4, fd4});
    end
  endtask

  task automatic test_cpb1();
    int drops0;
    drops0 = drop_cnt1;
    d1 = 8'hFF;
    @(negedge uart_clk);
    total++;
    if ({tx1, busy1} !== 2'b10) begin
      bad++;
      $display("FAIL cpb1_latency: got tx/busy=%b want 10", {tx1, busy1});
    end
    @(negedge uart_clk);
    for (int k = 0; k < 10; k++) begin
      total++;
      if (tx1 !== exp_tx(8'hFF, k, 1) || busy1 !== 1'b1) begin
        bad++;
        $display("FAIL cpb1_FF k=%0d: got tx=%b busy=%b want tx=%b busy=1", k, tx1, busy1,
                 exp_tx(8'hFF, k, 1));
      end
      if (k == 0) d1 = 8'h00;
      @(negedge uart_clk);
    end
    total++;
    if ({tx1, busy1, fd1} !== 3'b101) begin
      bad++;
      $display("FAIL cpb1_gap: got tx/busy/fd=%b want 101", {tx1, busy1, fd1});
    end
    @(negedge uart_clk);
    for (int k = 0; k < 10; k++) begin
      total++;
      if (tx1 !== exp_tx(8'h00, k, 1) || busy1 !== 1'b1) begin
        bad++;
        $display("FAIL cpb1_00 k=%0d: got tx=%b busy=%b want tx=%b busy=1", k, tx1, busy1,
                 exp_tx(8'h00, k, 1));
      end
      @(negedge uart_clk);
    end
    total++;
    if ({tx1, busy1, fd1} !== 3'b101) begin
      bad++;
      $display("FAIL cpb1_done: got tx/busy/fd=%b want 101", {tx1, busy1, fd1});
    end
    @(negedge uart_clk);
    total++;
    if ({tx1, busy1, fd1} !== 3'b100 || drop_cnt1 - drops0 !== 0) begin
      bad++;
      $display("FAIL cpb1_idle: got tx/busy/fd=%b drops=%0d want 100 drops=0", {tx1, busy1, fd1},
               drop_cnt1 - drops0);
    end
  endtask

  initial begin
    test_reset();
    test_frame_drop();
    test_back_to_back();
    test_reset_midframe();
    test_cpb1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
